seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter CLK_DIV, default 50000, clock cycles per digit slot (>= 2).
REQ-003 Parameter BLANK_CYCLES, default 16, anti-ghosting dead time at start of each slot (0..CLK_DIV-1).
REQ-004 Parameter LZ_BLANK, default 0, 1 = suppress leading zeros.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1, segment and dp polarity.
REQ-006 Parameter AN_ACTIVE_LOW, default 1, anode polarity.
REQ-007 Port clk input 1, single clock; all state on rising edge.
REQ-008 Port rst input 1, asynchronous, active-high reset.
REQ-009 Port data input 4*N_DIGITS, hex nibbles; digit 0 = data[3:0] = least significant.
REQ-010 Port dp input N_DIGITS, decimal point per digit, 1 = lit.
REQ-011 Port load input 1, single-cycle strobe capturing data and dp.
REQ-012 Port blank input 1, level; 1 = all anodes inactive.
REQ-013 Port seg output 7, segments {g,f,e,d,c,b,a}, seg[0] = a.
REQ-014 Port seg_dp output 1, decimal point segment.
REQ-015 Port an output N_DIGITS, digit enables, an[i] drives digit i.

Function
REQ-016 A prescaler cnt shall count 0..CLK_DIV-1 and wrap to 0; digit index idx shall advance on the wrap, N_DIGITS-1 -> 0.
REQ-017 On load = 1, data/dp shall go into a pending register and set a pending flag; a later load before application shall overwrite pending (latest wins).
REQ-018 Pending shall be copied to the display register, and the flag cleared, only in the cycle where idx wraps N_DIGITS-1 -> 0 (tear-free frame update).
REQ-019 A load in the same cycle as the frame wrap shall be applied at the next frame wrap, not the current one.
REQ-020 Glyphs (active-high, gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001.
REQ-021 With SEG_ACTIVE_LOW = 1, seg and seg_dp shall be the bitwise inverse of the active-high values.
REQ-022 During cnt < BLANK_CYCLES, or while blank = 1, all an bits shall be inactive and seg/seg_dp all-off.
REQ-023 Otherwise exactly one an bit, an[idx], shall be active, with seg = glyph(display nibble idx) and seg_dp = display dp[idx].
REQ-024 With LZ_BLANK = 1, a digit i > 0 shall be blanked (an[i] inactive in its slot) when it and every digit above it are zero; digit 0 shall never be LZ-blanked.
REQ-025 seg, seg_dp and an shall be registered, lagging cnt/idx by exactly one cycle.
REQ-026 Full frame period shall be N_DIGITS*CLK_DIV cycles.

Reset
REQ-027 On rst = 1, cnt = 0, idx = 0, pending flag = 0, pending and display registers = 0, immediately and asynchronously.
REQ-028 During reset, an shall be all inactive and seg/seg_dp all-off at the configured polarity.
REQ-029 After rst deasserts mid-scan, scanning shall restart at digit 0, cnt 0, and display zeros until the first applied load.

Structure
REQ-030 Shared package seg7_pkg shall hold the 16-entry glyph table constant and the polarity helper.
REQ-031 Sub-module seg7_glyph shall be the combinational nibble-to-segment lookup, instantiated once per driver.

Verification
REQ-032 N_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, defaults: reset, load data=16'h12AF -> slots show F,A,2,1 on an=1110,1101,1011,0111, each active 3 of 4 cycles.
REQ-033 Same config: load 16'h0000 then 16'h5678 within one frame -> only 5678 appears, first shown at the next digit-0 slot, no mixed frame.
REQ-034 LZ_BLANK=1: load 16'h0030 -> digits 3 and 2 anodes stay inactive, digit 1 shows 3, digit 0 shows 0.
REQ-035 blank held high for 10 cycles -> an=1111, seg=1111111 throughout; scanning position continues and resumes correctly.
REQ-036 rst asserted mid-slot of digit 2 -> an/seg all-off in the same cycle; after release, digit 0 slot first, display zero.
REQ-037 dp=4'b0100 with SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0 -> seg_dp=1 only in digit 2 slot; an one-hot active-high.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table and segment polarity helper.
package seg7_pkg;

  // Active-high gfedcba patterns, nibble n lives at bits [n*7 +: 7] (0 at the LSB end).
  localparam logic [111:0] GLYPH_ROM = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Converts an active-high {dp, gfedcba} byte to the board's pin polarity.
  function automatic logic [7:0] apply_polarity(input logic [7:0] value, input logic active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-high seven-segment pattern lookup.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Pick the 7-bit slice of the glyph table belonging to this nibble.
  always_comb begin
    glyph = GLYPH_ROM[7*int'(nibble) +: 7];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with tear-free frame updates,
// anti-ghosting dead time, optional leading-zero blanking and registered pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int LZ_BLANK       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  localparam logic                SEG_AL  = (SEG_ACTIVE_LOW != 0);
  localparam logic                AN_AL   = (AN_ACTIVE_LOW != 0);
  localparam logic [7:0]          SEG_OFF = apply_polarity(8'h00, SEG_AL);
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_AL}};

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_wrap;

  logic [4*N_DIGITS-1:0] pend_data;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  pend_flag;
  logic [4*N_DIGITS-1:0] disp_data;
  logic [N_DIGITS-1:0]   disp_dp;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [N_DIGITS-1:0]   an_onehot;
  logic [N_DIGITS-1:0]   lz_hide;
  logic                  upper_zero;
  logic                  dark;
  logic [6:0]            cur_glyph;
  logic [N_DIGITS-1:0]   an_next;
  logic [7:0]            segs_next;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // Prescaler walks each digit slot; the digit index steps when a slot ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Loads park in a pending buffer and only reach the display at a frame boundary,
  // so a frame never mixes old and new digits; a load on the boundary waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else begin
      if (frame_wrap && pend_flag) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp;
        pend_flag <= 1'b1;
      end else if (frame_wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // Select the current digit's nibble, dp and one-hot anode from the scan index.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib      = disp_data[i*4 +: 4];
        cur_dp       = disp_dp[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  // A digit above 0 is a leading zero when it and everything above it is zero.
  always_comb begin
    lz_hide    = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_data[i*4 +: 4] == 4'h0);
      lz_hide[i] = (LZ_BLANK != 0) && (i > 0) && upper_zero;
    end
  end

  seg7_glyph u_glyph (
    .nibble (cur_nib),
    .glyph  (cur_glyph)
  );

  // Decide the next pin values: dark during dead time, external blank or a hidden zero.
  always_comb begin
    dark      = blank || (cnt < CNT_BLANK) || (|(lz_hide & an_onehot));
    an_next   = AN_OFF;
    segs_next = SEG_OFF;
    if (!dark) begin
      an_next   = an_onehot ^ AN_OFF;
      segs_next = apply_polarity({cur_dp, cur_glyph}, SEG_AL);
    end
  end

  // Register the pins so they are glitch-free and lag the scan state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an            <= AN_OFF;
      {seg_dp, seg} <= SEG_OFF;
    end else begin
      an            <= an_next;
      {seg_dp, seg} <= segs_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three configurations (active-low default,
// leading-zero blanking, active-high pins) share one set of inputs.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        blank;

  logic [6:0]  seg_m, seg_l, seg_p;
  logic        sdp_m, sdp_l, sdp_p;
  logic [3:0]  an_m, an_l, an_p;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [27:0] glyphs;  // active-high patterns {d3,d2,d1,d0}
    logic [3:0]  lz_vis;  // digits that remain lit with leading-zero blanking
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(0),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_main (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank(blank),
    .seg(seg_m), .seg_dp(sdp_m), .an(an_m));

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_lz (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank(blank),
    .seg(seg_l), .seg_dp(sdp_l), .an(an_l));

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .LZ_BLANK(0),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_pol (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load), .blank(blank),
    .seg(seg_p), .seg_dp(sdp_p), .an(an_p));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                               input logic ld, input logic bl);
    data  = d;
    dp    = p;
    load  = ld;
    blank = bl;
  endtask

  // got/want packing: {an[3:0], seg[6:0], seg_dp}
  task automatic checkOutput(input string name, input int step_no,
                             input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, step_no, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
    end
  endtask

  // Expected pins for step j (0..15) of a frame window showing vector v.
  task automatic check_step(input vec_t v, input int j, input logic blanked, input string tag);
    int         slot;
    logic       off;
    logic [6:0] g;
    logic [3:0] oh;
    logic       d;
    logic [11:0] exp_m, exp_l, exp_p;
    slot = j / 4;
    off  = blanked || ((j % 4) == 0);
    g    = v.glyphs[slot*7 +: 7];
    oh   = 4'b0001 << slot;
    d    = v.dp[slot];
    exp_m = off ? 12'hFFF : {~oh, ~g, ~d};
    exp_l = (off || !v.lz_vis[slot]) ? 12'hFFF : {~oh, ~g, ~d};
    exp_p = off ? 12'h000 : {oh, g, d};
    checkOutput({tag, "/main"}, j, {an_m, seg_m, sdp_m}, exp_m);
    checkOutput({tag, "/lz"},   j, {an_l, seg_l, sdp_l}, exp_l);
    checkOutput({tag, "/pol"},  j, {an_p, seg_p, sdp_p}, exp_p);
  endtask

  // One full 16-cycle frame window with optional loads and a blank interval.
  task automatic run_window(input vec_t exp_v, input int lda_j, input vec_t lda,
                            input int ldb_j, input vec_t ldb,
                            input int bf, input int bt, input string tag);
    for (int j = 0; j < 16; j++) begin
      logic bl;
      bl = (j >= bf) && (j <= bt);
      if (j == lda_j)
        applyStimulus(lda.data, lda.dp, 1'b1, bl);
      else if (j == ldb_j)
        applyStimulus(ldb.data, ldb.dp, 1'b1, bl);
      else
        applyStimulus(data, dp, 1'b0, bl);
      step();
      check_step(exp_v, j, bl, tag);
    end
    applyStimulus(data, dp, 1'b0, 1'b0);
  endtask

  task automatic check_reset_pins(input string tag);
    checkOutput({tag, "/main"}, 0, {an_m, seg_m, sdp_m}, 12'hFFF);
    checkOutput({tag, "/lz"},   0, {an_l, seg_l, sdp_l}, 12'hFFF);
    checkOutput({tag, "/pol"},  0, {an_p, seg_p, sdp_p}, 12'h000);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0001};
    vecs[1] = '{16'h12AF, 4'b0000, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b1111};
    vecs[2] = '{16'h0030, 4'b0000, {7'h3F, 7'h3F, 7'h4F, 7'h3F}, 4'b0011};
    vecs[3] = '{16'h5678, 4'b0100, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111};
    vecs[4] = '{16'h9BCD, 4'b1001, {7'h6F, 7'h7C, 7'h39, 7'h5E}, 4'b1111};
    vecs[5] = '{16'h0E04, 4'b0010, {7'h3F, 7'h79, 7'h3F, 7'h66}, 4'b0111};
    vecs[6] = '{16'h0000, 4'b1111, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0001};
    vecs[7] = '{16'h3000, 4'b0000, {7'h4F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};

    rst = 1'b1;
    applyStimulus(16'h0000, 4'b0000, 1'b0, 1'b0);
    step();
    step();
    check_reset_pins("reset");
    rst = 1'b0;

    // Each window shows the previous table entry while loading the next one.
    for (int w = 0; w < 8; w++) begin
      if (w + 1 < 8)
        run_window(vecs[w], 0, vecs[w+1], -1, vecs[0], 99, -1, $sformatf("tbl%0d", w));
      else
        run_window(vecs[w], -1, vecs[0], -1, vecs[0], 99, -1, $sformatf("tbl%0d", w));
    end

    // Two loads in one frame: the frame in progress stays intact, latest wins.
    run_window(vecs[7], 2, vecs[0], 9, vecs[3], 99, -1, "latest");
    run_window(vecs[3], -1, vecs[0], -1, vecs[0], 3, 12, "blank");
    run_window(vecs[3], -1, vecs[0], -1, vecs[0], 99, -1, "resume");

    // A load coinciding with the frame boundary waits one extra frame.
    run_window(vecs[3], 15, vecs[1], -1, vecs[0], 99, -1, "wrapload");
    run_window(vecs[3], -1, vecs[0], -1, vecs[0], 99, -1, "deferred");
    run_window(vecs[1], -1, vecs[0], -1, vecs[0], 99, -1, "applied");

    // Reset in the middle of digit 2's slot with a load still pending.
    for (int j = 0; j < 10; j++) begin
      if (j == 2)
        applyStimulus(vecs[4].data, vecs[4].dp, 1'b1, 1'b0);
      else
        applyStimulus(data, dp, 1'b0, 1'b0);
      step();
      check_step(vecs[1], j, 1'b0, "prerst");
    end
    rst = 1'b1;
    #1;
    check_reset_pins("rstasync");
    step();
    step();
    check_reset_pins("rsthold");
    rst = 1'b0;
    run_window(vecs[0], -1, vecs[0], -1, vecs[0], 99, -1, "postrst");
    run_window(vecs[0], -1, vecs[0], -1, vecs[0], 99, -1, "pendclr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
